// File: rtl/adder_pkg.sv
// Shared definitions for the adder IP: register offsets, bit positions, FSM and bus response enums.
package adder_pkg;

    localparam logic [31:0] ADDR_CTRL   = 32'h0000_0000;
    localparam logic [31:0] ADDR_STATUS = 32'h0000_0004;
    localparam logic [31:0] ADDR_OP_A   = 32'h0000_0008;
    localparam logic [31:0] ADDR_OP_B   = 32'h0000_000C;
    localparam logic [31:0] ADDR_RESULT = 32'h0000_0010;
    localparam logic [31:0] ADDR_LAST   = 32'h0000_0014;

    localparam int CTRL_START_BIT   = 0;
    localparam int CTRL_IRQ_EN_BIT  = 1;
    localparam int STATUS_BUSY_BIT  = 0;
    localparam int STATUS_DONE_BIT  = 1;
    localparam int STATUS_CARRY_BIT = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_ADD  = 2'd2,
        ST_WB   = 2'd3
    } CTRL_STATE_E;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } AXI_RESP_E;

    // Only the low 256-byte window is decoded; anything else is unmapped.
    function automatic logic reg_hit(input logic [31:0] addr, input logic [31:0] offset);
        return (addr[31:8] == 24'd0) && (addr[7:0] == offset[7:0]) && (offset < ADDR_LAST);
    endfunction

    function automatic logic [31:0] strb_merge(input logic [31:0] cur,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  strb);
        logic [31:0] merged;
        merged = cur;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) merged[8*i +: 8] = wdata[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/adder_ctrl_if.sv
// Register-access bundle between the AXI4-Lite front end (master) and adder_ctrl (slave).
interface adder_ctrl_if;

    logic        i_en_amba_write;
    logic [31:0] i_data_wc;
    logic [31:0] i_addr_wc;
    logic [3:0]  i_strb;
    logic [31:0] i_addr_rc;
    logic [31:0] o_data_rc;
    logic        o_is_busy;

    modport master (
        output i_en_amba_write, i_data_wc, i_addr_wc, i_strb, i_addr_rc,
        input  o_data_rc, o_is_busy
    );

    modport slave (
        input  i_en_amba_write, i_data_wc, i_addr_wc, i_strb, i_addr_rc,
        output o_data_rc, o_is_busy
    );

endinterface

// File: rtl/adder_serial_dp.sv
// Lane-serial 32-bit adder: operand shift registers, LANE_WIDTH adder with carry flop, accumulator.
module adder_serial_dp #(
    parameter int LANE_WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic [31:0] sum,
    output logic        carry
);

    logic [31:0]         a_sh;
    logic [31:0]         b_sh;
    logic [31:0]         acc;
    logic [31:0]         acc_next;
    logic                carry_q;
    logic [LANE_WIDTH:0] lane_sum;

    assign lane_sum = {1'b0, a_sh[LANE_WIDTH-1:0]}
                    + {1'b0, b_sh[LANE_WIDTH-1:0]}
                    + {{LANE_WIDTH{1'b0}}, carry_q};

    // Each new slice enters at the top so the first (LSB) slice ends at bit 0.
    if (LANE_WIDTH == 32) begin : g_full
        assign acc_next = lane_sum[31:0];
    end else begin : g_part
        assign acc_next = {lane_sum[LANE_WIDTH-1:0], acc[31:LANE_WIDTH]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh    <= '0;
            b_sh    <= '0;
            acc     <= '0;
            carry_q <= 1'b0;
        end else if (load) begin
            a_sh    <= op_a;
            b_sh    <= op_b;
            acc     <= '0;
            carry_q <= 1'b0;
        end else if (step) begin
            a_sh    <= a_sh >> LANE_WIDTH;
            b_sh    <= b_sh >> LANE_WIDTH;
            acc     <= acc_next;
            carry_q <= lane_sum[LANE_WIDTH];
        end
    end

    assign sum   = acc;
    assign carry = carry_q;

endmodule

// File: rtl/adder_ctrl.sv
// Register bank and sequencing FSM for the AXI4-Lite adder IP.
// Optional interrupt output enabled by defining ADDER_CTRL_IRQ_EN.
module adder_ctrl
    import adder_pkg::*;
#(
    parameter int LANE_WIDTH = 8
) (
    input  logic S_AXI_ACLK,
    input  logic S_AXI_ARESETN,
`ifdef ADDER_CTRL_IRQ_EN
    output logic o_irq,
`endif
    adder_ctrl_if.slave bus
);

    localparam int NUM_LANES = 32 / LANE_WIDTH;
    localparam int CNT_W     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_LANES - 1);

    CTRL_STATE_E      state;
    CTRL_STATE_E      state_next;
    logic [CNT_W-1:0] lane_cnt;

    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] result;
    logic        done;
    logic        carry;
    logic        irq_en;
    logic        busy;

    logic        dp_load;
    logic        dp_step;
    logic [31:0] dp_sum;
    logic        dp_carry;

    logic wr_idle;
    logic wr_ctrl;
    logic wr_status;
    logic wr_op_a;
    logic wr_op_b;
    logic start;
    logic done_clr;

    // Bus writes are only honoured while idle, so operands stay stable during an add.
    assign wr_idle   = bus.i_en_amba_write && (state == ST_IDLE);
    assign wr_ctrl   = wr_idle && reg_hit(bus.i_addr_wc, ADDR_CTRL);
    assign wr_status = wr_idle && reg_hit(bus.i_addr_wc, ADDR_STATUS);
    assign wr_op_a   = wr_idle && reg_hit(bus.i_addr_wc, ADDR_OP_A);
    assign wr_op_b   = wr_idle && reg_hit(bus.i_addr_wc, ADDR_OP_B);
    assign start     = wr_ctrl && bus.i_strb[0] && bus.i_data_wc[CTRL_START_BIT];
    assign done_clr  = wr_status && bus.i_strb[0] && bus.i_data_wc[STATUS_DONE_BIT];

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) state <= ST_IDLE;
        else                state <= state_next;
    end

    always_comb begin
        state_next = state;
        dp_load    = 1'b0;
        dp_step    = 1'b0;
        case (state)
            ST_IDLE: if (start) state_next = ST_LOAD;
            ST_LOAD: begin
                dp_load    = 1'b1;
                state_next = ST_ADD;
            end
            ST_ADD: begin
                dp_step = 1'b1;
                if (lane_cnt == CNT_LAST) state_next = ST_WB;
            end
            ST_WB:   state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN)         lane_cnt <= '0;
        else if (state == ST_LOAD)  lane_cnt <= '0;
        else if (state == ST_ADD)   lane_cnt <= lane_cnt + CNT_W'(1);
    end

    adder_serial_dp #(
        .LANE_WIDTH(LANE_WIDTH)
    ) u_dp (
        .clk   (S_AXI_ACLK),
        .rst_n (S_AXI_ARESETN),
        .load  (dp_load),
        .step  (dp_step),
        .op_a  (op_a),
        .op_b  (op_b),
        .sum   (dp_sum),
        .carry (dp_carry)
    );

    // The write-back assignment to done comes last so a set beats a same-cycle clear.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            op_a   <= '0;
            op_b   <= '0;
            result <= '0;
            carry  <= 1'b0;
            done   <= 1'b0;
        end else begin
            if (wr_op_a) op_a <= strb_merge(op_a, bus.i_data_wc, bus.i_strb);
            if (wr_op_b) op_b <= strb_merge(op_b, bus.i_data_wc, bus.i_strb);
            if (start || done_clr) done <= 1'b0;
            if (state == ST_WB) begin
                result <= dp_sum;
                carry  <= dp_carry;
                done   <= 1'b1;
            end
        end
    end

`ifdef ADDER_CTRL_IRQ_EN
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN)                   irq_en <= 1'b0;
        else if (wr_ctrl && bus.i_strb[0])    irq_en <= bus.i_data_wc[CTRL_IRQ_EN_BIT];
    end

    assign o_irq = done & irq_en;
`else
    assign irq_en = 1'b0;
`endif

    assign busy          = (state != ST_IDLE);
    assign bus.o_is_busy = busy;

    always_comb begin
        bus.o_data_rc = '0;
        if (reg_hit(bus.i_addr_rc, ADDR_CTRL)) begin
            bus.o_data_rc[CTRL_IRQ_EN_BIT] = irq_en;
        end else if (reg_hit(bus.i_addr_rc, ADDR_STATUS)) begin
            bus.o_data_rc[STATUS_BUSY_BIT]  = busy;
            bus.o_data_rc[STATUS_DONE_BIT]  = done;
            bus.o_data_rc[STATUS_CARRY_BIT] = carry;
        end else if (reg_hit(bus.i_addr_rc, ADDR_OP_A)) begin
            bus.o_data_rc = op_a;
        end else if (reg_hit(bus.i_addr_rc, ADDR_OP_B)) begin
            bus.o_data_rc = op_b;
        end else if (reg_hit(bus.i_addr_rc, ADDR_RESULT)) begin
            bus.o_data_rc = result;
        end
    end

endmodule
